// File: rtl/mem_issue_queue.sv
// In-order two-wide memory-op issue queue feeding the LSU's two op ports.
// Circular buffer, compacting two-lane enqueue, head/head+1 issue with
// same-8-byte-block split when either op is a store.

// One issue slot's output register: captures the selected entry on issue,
// holds the payload otherwise, valid is a single-cycle pulse.
module mem_issue_lane (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        iss,
  input  logic        st,
  input  logic [63:0] addr,
  input  logic [63:0] data,
  input  logic [2:0]  size,
  input  logic [6:0]  dest,
  input  logic [7:0]  rob,
  output logic        vld_q,
  output logic        st_q,
  output logic [63:0] addr_q,
  output logic [63:0] data_q,
  output logic [2:0]  size_q,
  output logic [6:0]  dest_q,
  output logic [7:0]  rob_q
);

  // Valid pulses on issue; payload only updates when a new op lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      st_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      size_q <= '0;
      dest_q <= '0;
      rob_q  <= '0;
    end else begin
      vld_q <= iss & ~flush;
      if (iss && !flush) begin
        st_q   <= st;
        addr_q <= addr;
        data_q <= data;
        size_q <= size;
        dest_q <= dest;
        rob_q  <= rob;
      end
    end
  end

endmodule

module mem_issue_queue #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       enq_valid_i,
  input  logic [1:0]       enq_is_store_i,
  input  logic [1:0][63:0] enq_addr_i,
  input  logic [1:0][63:0] enq_store_data_i,
  input  logic [1:0][2:0]  enq_store_size_i,
  input  logic [1:0][6:0]  enq_dest_phys_i,
  input  logic [1:0][7:0]  enq_rob_idx_i,
  output logic             enq_ready_o,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic [1:0]       op_valid_o,
  output logic [1:0]       op_is_store_o,
  output logic [1:0][63:0] op_addr_o,
  output logic [1:0][63:0] op_store_data_o,
  output logic [1:0][2:0]  op_store_size_o,
  output logic [1:0][6:0]  op_dest_phys_o,
  output logic [1:0][7:0]  op_rob_idx_o,
  output logic [CW-1:0]    count_o
);

  localparam int AW = $clog2(DEPTH);

  // Entry storage; contents are never cleared, only pointers/count matter.
  logic        q_st   [DEPTH];
  logic [63:0] q_addr [DEPTH];
  logic [63:0] q_data [DEPTH];
  logic [2:0]  q_size [DEPTH];
  logic [6:0]  q_dest [DEPTH];
  logic [7:0]  q_rob  [DEPTH];

  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_idx [2];
  logic [1:0]    iss;
  logic [1:0]    n_iss, n_enq;
  logic          conflict, enq_fire, wr0, wr1, sel0;

  assign count_o     = count;
  assign enq_ready_o = (count <= CW'(DEPTH - 2));

  assign rd_idx[0] = head;
  assign rd_idx[1] = head + AW'(1);

  // Two ops touching the same 8-byte block may clash in the D-cache if
  // either writes, so the younger one waits a cycle.
  assign conflict = (q_st[rd_idx[0]] | q_st[rd_idx[1]]) &
                    (q_addr[rd_idx[0]][63:3] == q_addr[rd_idx[1]][63:3]);

  // Issue selection looks only at entries present before this edge.
  assign iss[0] = ~flush_i & ~stall_i & (count != '0);
  assign iss[1] = iss[0] & (count >= CW'(2)) & ~conflict;
  assign n_iss  = {1'b0, iss[0]} + {1'b0, iss[1]};

  // Enqueue compacts valid lanes onto tail, tail+1; flush drops it.
  assign enq_fire = enq_ready_o & ~flush_i;
  assign wr0      = enq_fire & (|enq_valid_i);
  assign wr1      = enq_fire & (&enq_valid_i);
  assign sel0     = ~enq_valid_i[0];
  assign n_enq    = enq_fire ? ({1'b0, enq_valid_i[0]} + {1'b0, enq_valid_i[1]}) : 2'd0;

  // Entry writes: first valid lane to tail, lane1 to tail+1 when both valid.
  always_ff @(posedge clk) begin
    if (wr0) begin
      q_st[tail]   <= enq_is_store_i[sel0];
      q_addr[tail] <= enq_addr_i[sel0];
      q_data[tail] <= enq_store_data_i[sel0];
      q_size[tail] <= enq_store_size_i[sel0];
      q_dest[tail] <= enq_dest_phys_i[sel0];
      q_rob[tail]  <= enq_rob_idx_i[sel0];
    end
    if (wr1) begin
      q_st[tail + AW'(1)]   <= enq_is_store_i[1];
      q_addr[tail + AW'(1)] <= enq_addr_i[1];
      q_data[tail + AW'(1)] <= enq_store_data_i[1];
      q_size[tail + AW'(1)] <= enq_store_size_i[1];
      q_dest[tail + AW'(1)] <= enq_dest_phys_i[1];
      q_rob[tail + AW'(1)]  <= enq_rob_idx_i[1];
    end
  end

  // Pointer and occupancy update; flush wins over enqueue and issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(n_iss);
      tail  <= tail + AW'(n_enq);
      count <= count + CW'(n_enq) - CW'(n_iss);
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_lane
    mem_issue_lane u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush_i),
      .iss    (iss[k]),
      .st     (q_st[rd_idx[k]]),
      .addr   (q_addr[rd_idx[k]]),
      .data   (q_data[rd_idx[k]]),
      .size   (q_size[rd_idx[k]]),
      .dest   (q_dest[rd_idx[k]]),
      .rob    (q_rob[rd_idx[k]]),
      .vld_q  (op_valid_o[k]),
      .st_q   (op_is_store_o[k]),
      .addr_q (op_addr_o[k]),
      .data_q (op_store_data_o[k]),
      .size_q (op_store_size_o[k]),
      .dest_q (op_dest_phys_o[k]),
      .rob_q  (op_rob_idx_o[k])
    );
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Bench for mem_issue_queue: queue-level reference model plus scoreboard.
module tb_mem_issue_queue;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic        st;
    logic [63:0] addr;
    logic [63:0] data;
    logic [2:0]  sz;
    logic [6:0]  dest;
    logic [7:0]  rob;
  } op_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       enq_valid_i;
  logic [1:0]       enq_is_store_i;
  logic [1:0][63:0] enq_addr_i;
  logic [1:0][63:0] enq_store_data_i;
  logic [1:0][2:0]  enq_store_size_i;
  logic [1:0][6:0]  enq_dest_phys_i;
  logic [1:0][7:0]  enq_rob_idx_i;
  logic             enq_ready_o;
  logic             stall_i;
  logic             flush_i;
  logic [1:0]       op_valid_o;
  logic [1:0]       op_is_store_o;
  logic [1:0][63:0] op_addr_o;
  logic [1:0][63:0] op_store_data_o;
  logic [1:0][2:0]  op_store_size_o;
  logic [1:0][6:0]  op_dest_phys_o;
  logic [1:0][7:0]  op_rob_idx_o;
  logic [CW-1:0]    count_o;

  mem_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enq_valid_i      (enq_valid_i),
    .enq_is_store_i   (enq_is_store_i),
    .enq_addr_i       (enq_addr_i),
    .enq_store_data_i (enq_store_data_i),
    .enq_store_size_i (enq_store_size_i),
    .enq_dest_phys_i  (enq_dest_phys_i),
    .enq_rob_idx_i    (enq_rob_idx_i),
    .enq_ready_o      (enq_ready_o),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .op_valid_o       (op_valid_o),
    .op_is_store_o    (op_is_store_o),
    .op_addr_o        (op_addr_o),
    .op_store_data_o  (op_store_data_o),
    .op_store_size_o  (op_store_size_o),
    .op_dest_phys_o   (op_dest_phys_o),
    .op_rob_idx_o     (op_rob_idx_o),
    .count_o          (count_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic conf(input op_t a, input op_t b);
    return (a.st | b.st) && (a.addr[63:3] == b.addr[63:3]);
  endfunction

  function automatic op_t dut_op(input int k);
    return {op_is_store_o[k], op_addr_o[k], op_store_data_o[k],
            op_store_size_o[k], op_dest_phys_o[k], op_rob_idx_o[k]};
  endfunction

  function automatic op_t lane_op(input int k);
    return {enq_is_store_i[k], enq_addr_i[k], enq_store_data_i[k],
            enq_store_size_i[k], enq_dest_phys_i[k], enq_rob_idx_i[k]};
  endfunction

  // Reference model: program-order queue of ops; sb holds ops expected
  // on the issue ports in order, hold the last op shown per slot.
  op_t        mq[$];
  op_t        sb[$];
  op_t        hold [2];
  logic [1:0] exp_vld;
  int         m_n, m_iss;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      sb.delete();
      hold[0] = '0;
      hold[1] = '0;
      exp_vld = 2'b00;
    end else if (flush_i) begin
      mq.delete();
      exp_vld = 2'b00;
    end else begin
      m_n   = mq.size();
      m_iss = 0;
      if (!stall_i && m_n >= 1) begin
        m_iss = 1;
        if (m_n >= 2 && !conf(mq[0], mq[1])) m_iss = 2;
      end
      for (int k = 0; k < m_iss; k++) begin
        hold[k] = mq.pop_front();
        sb.push_back(hold[k]);
      end
      exp_vld = (m_iss == 2) ? 2'b11 : (m_iss == 1) ? 2'b01 : 2'b00;
      if (m_n <= DEPTH - 2) begin
        if (enq_valid_i[0]) mq.push_back(lane_op(0));
        if (enq_valid_i[1]) mq.push_back(lane_op(1));
      end
    end
  end

  // Monitor: compares DUT outputs with the model away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("count", 160'(count_o), 160'(mq.size()));
      chk("enq_ready", 160'(enq_ready_o), 160'(mq.size() <= DEPTH - 2));
      chk("op_valid", 160'(op_valid_o), 160'(exp_vld));
      for (int k = 0; k < 2; k++) begin
        if (op_valid_o[k]) begin
          if (sb.size() == 0) chk("issue_unexpected", 160'(dut_op(k)), 160'(0));
          else chk("issue_payload", 160'(dut_op(k)), 160'(sb.pop_front()));
        end
        chk("payload_hold", 160'(dut_op(k)), 160'(hold[k]));
      end
    end
  end

  logic [7:0] rob_ctr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq_valid_i = 2'b00;
  endtask

  task automatic set_lane(input int k, input logic st, input logic [63:0] a);
    enq_is_store_i[k]   = st;
    enq_addr_i[k]       = a;
    enq_store_data_i[k] = {$urandom, $urandom};
    enq_store_size_i[k] = 3'($urandom_range(0, 3));
    enq_dest_phys_i[k]  = 7'($urandom);
    enq_rob_idx_i[k]    = rob_ctr;
    rob_ctr++;
  endtask

  task automatic enq2(input logic st0, input logic [63:0] a0, input logic st1, input logic [63:0] a1);
    enq_valid_i = 2'b11;
    set_lane(0, st0, a0);
    set_lane(1, st1, a1);
  endtask

  initial begin
    rst_n = 1'b1; stall_i = 1'b0; flush_i = 1'b0; rob_ctr = 8'd1;
    enq_valid_i = '0; enq_is_store_i = '0; enq_addr_i = '0; enq_store_data_i = '0;
    enq_store_size_i = '0; enq_dest_phys_i = '0; enq_rob_idx_i = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_count", 160'(count_o), 160'(0));
    chk("reset_valid", 160'(op_valid_o), 160'(0));
    chk("reset_ready", 160'(enq_ready_o), 160'(1));
    chk("reset_payload0", 160'(dut_op(0)), 160'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Two loads in one cycle, issued together two edges later.
    enq2(1'b0, 64'h1000, 1'b0, 64'h2000);
    step(); idle(); step();
    chk("dual_issue_valid", 160'(op_valid_o), 160'(2'b11));
    chk("dual_issue_rob", 160'({op_rob_idx_o[1], op_rob_idx_o[0]}), 160'({8'd2, 8'd1}));
    step(); step();

    // Store/load in the same 8-byte block split across cycles.
    enq2(1'b1, 64'h1008, 1'b0, 64'h100C);
    step(); idle(); step(); step(); step();

    // Fill while stalled up to the full boundary, then drain.
    stall_i = 1'b1;
    enq_valid_i = 2'b01; set_lane(0, 1'b0, 64'h3000);
    step();
    for (int i = 0; i < 9; i++) begin
      enq2(1'b0, 64'h4000 + 64'(i * 32), 1'b0, 64'h4010 + 64'(i * 32));
      step();
    end
    idle(); stall_i = 1'b0;
    repeat (12) step();

    // Lane1-only then both lanes: order 5, 6, 7.
    rob_ctr = 8'd5;
    enq_valid_i = 2'b10; set_lane(1, 1'b0, 64'h5000);
    step();
    enq2(1'b0, 64'h6000, 1'b0, 64'h7000);
    step(); idle();
    repeat (4) step();

    // Flush with same-cycle enqueue while holding six ops.
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      enq2(1'b0, 64'h8000 + 64'(i * 32), 1'b1, 64'h8010 + 64'(i * 32));
      step();
    end
    flush_i = 1'b1; enq2(1'b0, 64'h9000, 1'b0, 64'h9100);
    step();
    flush_i = 1'b0; stall_i = 1'b0; idle();
    chk("flush_count", 160'(count_o), 160'(0));
    repeat (4) step();

    // Randomized traffic with conflicts, stalls, flushes and pointer wrap.
    for (int i = 0; i < 1500; i++) begin
      enq_valid_i = 2'($urandom);
      for (int k = 0; k < 2; k++)
        set_lane(k, 1'($urandom), 64'h1000 + 64'($urandom_range(0, 5) * 8) + 64'($urandom_range(0, 7)));
      stall_i = ($urandom_range(0, 3) == 0);
      flush_i = ($urandom_range(0, 49) == 0);
      step();
    end
    idle(); stall_i = 1'b0; flush_i = 1'b0;
    repeat (12) step();

    // Asynchronous reset while both slots are presenting ops.
    enq2(1'b0, 64'hA000, 1'b0, 64'hB000);
    step(); idle(); step();
    chk("pre_reset_valid", 160'(op_valid_o), 160'(2'b11));
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 160'(op_valid_o), 160'(0));
    chk("async_reset_count", 160'(count_o), 160'(0));
    chk("async_reset_payload1", 160'(dut_op(1)), 160'(0));
    step();
    rst_n = 1'b1;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
